axis_fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that lets NUM_PORTS AXI-Stream subordinate channels share one FIFO write port. It sits between several producers (per-channel DAC/ADC command streams) and a single FIFO write side, ahead of the FIFO-bridge read path. Grants last one packet, one bounded burst, or until the granted producer stalls, whichever comes first. It also reports the active grant and a sticky per-port overflow flag.

---
 rtl/axis_fifo_wr_arbiter_pkg.sv | 17 +
 rtl/axis_fifo_wr_arbiter_if.sv | 29 ++
 rtl/axis_fifo_wr_arbiter_rr_priority_pick.sv | 30 +++
 rtl/axis_fifo_wr_arbiter.sv | 86 ++++++++
 tb/tb_axis_fifo_wr_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_fifo_wr_arbiter_pkg.sv
// Shared types and constants for the AXI-Stream FIFO write-port arbiter.
package axis_fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Bits needed to hold values 0..value-1 (clog2(1) is 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/axis_fifo_wr_arbiter_if.sv
// Bundles the per-port AXI-Stream inputs and the shared FIFO write side.
//
// Handshake: a stream beat transfers on a rising edge where tvalid and tready
// are both high; a FIFO write happens on every edge where fifo_wr_en is high,
// and fifo_wr_en is never raised while fifo_full is high.
interface axis_fifo_wr_arbiter_if #(
  parameter int NUM_PORTS       = 4,
  parameter int AXIS_DATA_WIDTH = 32
);
  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS-1:0]                 s_axis_tvalid;
  logic [NUM_PORTS-1:0]                 s_axis_tlast;
  logic [NUM_PORTS-1:0]                 s_axis_tready;
  logic [AXIS_DATA_WIDTH-1:0]           fifo_wr_data;
  logic                                 fifo_wr_en;
  logic                                 fifo_full;

  // Arbiter side.
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, fifo_full,
    output s_axis_tready, fifo_wr_data, fifo_wr_en
  );

  // Producers and FIFO side.
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, fifo_full,
    input  s_axis_tready, fifo_wr_data, fifo_wr_en
  );
endinterface

// File: rtl/axis_fifo_wr_arbiter_rr_priority_pick.sv
// Round-robin search: first requesting port after last_idx, wrapping modulo NUM_PORTS.
module rr_priority_pick
  import axis_fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_idx,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);

  always_comb begin
    int cand;
    found = 1'b0;
    idx   = last_idx;
    cand  = 0;
    // Explicit subtract rather than %, so non-power-of-two port counts wrap cleanly.
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = int'(last_idx) + k;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/axis_fifo_wr_arbiter.sv
// Round-robin arbiter letting NUM_PORTS AXI-Stream producers share one FIFO write port.
// A grant lasts one packet, BURST_LEN beats, or until the granted producer idles.
module axis_fifo_wr_arbiter
  import axis_fifo_wr_arbiter_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int NUM_PORTS       = 4,
  parameter int BURST_LEN       = 16,
  parameter int IDX_W           = clog2(NUM_PORTS),
  parameter int CNT_W           = clog2(BURST_LEN + 1)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axis_fifo_wr_arbiter_if.slave bus,
  input  logic                  arb_enable,
  output logic                  grant_valid,
  output logic [IDX_W-1:0]      grant_idx,
  output logic [NUM_PORTS-1:0]  port_overflow,
  output arb_state_e            state,
  output logic [CNT_W-1:0]      beat_cnt
);

  logic [IDX_W-1:0] last_idx;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             sel_valid;
  logic             sel_last;
  logic             wr;

  rr_priority_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req      (bus.s_axis_tvalid),
    .last_idx (last_idx),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  assign sel_valid   = bus.s_axis_tvalid[grant_idx];
  assign sel_last    = bus.s_axis_tlast[grant_idx];
  assign wr          = (state == XFER) && sel_valid && !bus.fifo_full;
  assign grant_valid = (state == XFER);

  // Zero-latency data path: the granted port's beat goes straight to the FIFO.
  assign bus.fifo_wr_data = bus.s_axis_tdata[grant_idx*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
  assign bus.fifo_wr_en   = wr;

  always_comb begin
    bus.s_axis_tready = '0;
    if (state == XFER) bus.s_axis_tready[grant_idx] = !bus.fifo_full;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      grant_idx     <= '0;
      last_idx      <= IDX_W'(NUM_PORTS - 1);
      beat_cnt      <= '0;
      port_overflow <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_enable && pick_found) begin
            grant_idx <= pick_idx;
            last_idx  <= pick_idx;
            beat_cnt  <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (sel_valid && bus.fifo_full) port_overflow[grant_idx] <= 1'b1;
          // tlast and a full burst on the same beat collapse into one release.
          if (wr) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (sel_last || beat_cnt == CNT_W'(BURST_LEN - 1)) state <= IDLE;
          end else if (!sel_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_fifo_wr_arbiter.sv
// Directed and randomized bench for axis_fifo_wr_arbiter, checked cycle by cycle
// against a grant/release model and a write-data scoreboard.
module tb_axis_fifo_wr_arbiter;
  import axis_fifo_wr_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int B  = 16;
  localparam int IW = clog2(N);
  localparam int CW = clog2(B + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic arb_enable = 1'b1;
  logic grant_valid;
  logic [IW-1:0] grant_idx;
  logic [N-1:0] port_overflow;
  arb_state_e state;
  logic [CW-1:0] beat_cnt;

  always #5 clk = ~clk;

  axis_fifo_wr_arbiter_if #(.NUM_PORTS(N), .AXIS_DATA_WIDTH(W)) bus ();

  axis_fifo_wr_arbiter #(
    .AXIS_DATA_WIDTH(W), .NUM_PORTS(N), .BURST_LEN(B)
  ) dut (
    .aclk          (clk),
    .aresetn       (rstn),
    .bus           (bus.slave),
    .arb_enable    (arb_enable),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx),
    .port_overflow (port_overflow),
    .state         (state),
    .beat_cnt      (beat_cnt)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // Producer state: beats left in each port's current packet, and forced idles.
  int remaining[N];
  logic [N-1:0] hold;

  // Reference model in terms of "who owns the FIFO and how many beats so far".
  bit m_busy;
  int m_idx, m_last, m_beats;
  logic [N-1:0] m_ovf;

  // Mid-cycle samples for directed checks.
  logic s_gv, s_wr;
  int s_idx, s_cnt;
  logic [N-1:0] s_rdy, s_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_idx = 0; m_last = N - 1; m_beats = 0; m_ovf = '0;
  endtask

  task automatic model_step(input logic rst_n, input logic en, input logic [N-1:0] v,
                            input logic [N-1:0] l, input logic f, input logic w);
    int p;
    if (!rst_n) begin
      model_reset();
    end else if (!m_busy) begin
      if (en) begin
        for (int k = 1; k <= N; k++) begin
          p = (m_last + k) % N;
          if (v[p] && !m_busy) begin
            m_busy = 1'b1; m_idx = p; m_last = p; m_beats = 0;
          end
        end
      end
    end else begin
      if (v[m_idx] && f) m_ovf[m_idx] = 1'b1;
      if (w) begin
        m_beats++;
        if (l[m_idx] || m_beats == B) m_busy = 1'b0;
      end else if (!v[m_idx]) begin
        m_busy = 1'b0;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.s_axis_tvalid[i] = (remaining[i] > 0) && !hold[i];
      bus.s_axis_tlast[i]  = (remaining[i] == 1);
      bus.s_axis_tdata[i*W +: W] = $urandom;
    end
  endtask

  // One clock: drive, compare at mid-cycle, advance model and producers at the edge.
  task automatic cycle();
    logic [N-1:0] e_rdy, v, l;
    logic e_wr, f, en, r;
    logic [W-1:0] got;
    drive();
    #4;
    v = bus.s_axis_tvalid; l = bus.s_axis_tlast; f = bus.fifo_full;
    en = arb_enable; r = rstn;
    e_wr  = m_busy && v[m_idx] && !f;
    e_rdy = '0;
    if (m_busy) e_rdy[m_idx] = !f;
    if (e_wr) exp_q.push_back(bus.s_axis_tdata[m_idx*W +: W]);
    chk("tready", bus.s_axis_tready, e_rdy);
    chk("wr_en", bus.fifo_wr_en, e_wr);
    chk("grant_valid", grant_valid, m_busy);
    chk("grant_idx", grant_idx, m_idx);
    chk("overflow", port_overflow, m_ovf);
    chk("beat_cnt", beat_cnt, m_beats);
    if (bus.fifo_wr_en === 1'b1) begin
      chk("sb_nonempty", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        got = bus.fifo_wr_data;
        chk("wr_data", got, exp_q.pop_front());
      end
    end
    s_gv = grant_valid; s_wr = bus.fifo_wr_en; s_idx = grant_idx; s_cnt = beat_cnt;
    s_rdy = bus.s_axis_tready; s_ovf = port_overflow;
    @(posedge clk);
    if (e_wr) remaining[m_idx]--;
    model_step(r, en, v, l, f, e_wr);
    #1;
  endtask

  task automatic reset_all();
    for (int i = 0; i < N; i++) remaining[i] = 0;
    hold = '0; bus.fifo_full = 1'b0; arb_enable = 1'b1;
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] gv6, wr6;
    logic gv_log[64], wr_log[64];
    int idx_log[64];
    logic [N-1:0] rdy_log[64], ovf_log[64];
    int grant_q[$], cnt_q[$];
    int idle_cnt, wr_cnt, gv_cnt, cnt_first, cnt_last;
    bit prev_gv, done;

    for (int i = 0; i < N; i++) remaining[i] = 0;
    hold = '0; bus.fifo_full = 1'b0;
    bus.s_axis_tvalid = '0; bus.s_axis_tlast = '0; bus.s_axis_tdata = '0;
    rstn = 1'b0;
    @(posedge clk); #1;
    model_reset();

    // Reset state (cycle checks compare against the model's reset values).
    cycle();
    chk("reset_ready", bus.s_axis_tready, '0);
    chk("reset_idx", grant_idx, 0);
    rstn = 1'b1;

    // Single 3-beat packet on port 0.
    reset_all();
    remaining[0] = 3;
    for (int c = 0; c < 6; c++) begin
      cycle();
      gv6[c] = s_gv; wr6[c] = s_wr; idx_log[c] = s_idx;
    end
    chk("t1_gv", gv6, 6'b001110);
    chk("t1_wr", wr6, 6'b001110);
    chk("t1_idx", idx_log[1], 0);
    chk("t1_ovf", port_overflow, '0);

    // Round-robin with all ports saturating.
    reset_all();
    for (int i = 0; i < N; i++) remaining[i] = 1000;
    prev_gv = 1'b0; idle_cnt = 0;
    for (int c = 0; c < 91; c++) begin
      cycle();
      if (s_gv && !prev_gv) begin grant_q.push_back(s_idx); cnt_q.push_back(0); end
      if (s_wr && cnt_q.size() > 0) cnt_q[cnt_q.size()-1]++;
      if (!s_gv && c >= 1 && c <= 84) idle_cnt++;
      prev_gv = s_gv;
    end
    chk("t2_ngrants", grant_q.size() >= 5, 1'b1);
    if (grant_q.size() >= 5) begin
      for (int g = 0; g < 5; g++) begin
        chk($sformatf("t2_order%0d", g), grant_q[g], g % N);
        chk($sformatf("t2_beats%0d", g), cnt_q[g], B);
      end
    end
    chk("t2_bubbles", idle_cnt, 4);

    // Gap release on port 2 with port 3 waiting.
    reset_all();
    remaining[2] = 20;
    for (int c = 0; c < 13; c++) begin
      if (c == 3) remaining[3] = 4;
      hold[2] = (c == 6);
      cycle();
      gv_log[c] = s_gv; wr_log[c] = s_wr; idx_log[c] = s_idx;
    end
    wr_cnt = 0;
    for (int c = 1; c <= 6; c++) if (wr_log[c]) wr_cnt++;
    chk("t3_first_idx", idx_log[1], 2);
    chk("t3_beats", wr_cnt, 5);
    chk("t3_gap_gv", gv_log[6], 1'b1);
    chk("t3_bubble", gv_log[7], 1'b0);
    chk("t3_next_gv", gv_log[8], 1'b1);
    chk("t3_next_idx", idx_log[8], 3);

    // Backpressure mid-burst on port 1.
    reset_all();
    remaining[1] = 30;
    for (int c = 0; c < 4; c++) cycle();
    bus.fifo_full = 1'b1;
    wr_cnt = 0; gv_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (c == 0) cnt_first = s_cnt;
      cnt_last = s_cnt;
      if (s_wr) wr_cnt++;
      if (s_gv) gv_cnt++;
    end
    chk("t4_no_writes", wr_cnt, 0);
    chk("t4_grant_held", gv_cnt, 10);
    chk("t4_cnt_first", cnt_first, 3);
    chk("t4_cnt_last", cnt_last, 3);
    chk("t4_ovf", port_overflow, 4'b0010);
    bus.fifo_full = 1'b0;
    wr_cnt = 3; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      cycle();
      if (s_wr) wr_cnt++;
      if (!s_gv) done = 1'b1;
    end
    chk("t4_released", done, 1'b1);
    chk("t4_total_beats", wr_cnt, B);

    // arb_enable low while port 0 bursts.
    reset_all();
    remaining[0] = 5; remaining[1] = 3;
    for (int c = 0; c < 13; c++) begin
      arb_enable = !(c >= 2 && c < 10);
      cycle();
      gv_log[c] = s_gv; idx_log[c] = s_idx; wr_log[c] = s_wr;
    end
    chk("t5_burst_idx", idx_log[1], 0);
    chk("t5_last_beat", wr_log[5], 1'b1);
    gv_cnt = 0;
    for (int c = 6; c <= 10; c++) if (gv_log[c]) gv_cnt++;
    chk("t5_no_grant", gv_cnt, 0);
    chk("t5_regrant_gv", gv_log[11], 1'b1);
    chk("t5_regrant_idx", idx_log[11], 1);

    // Reset mid-burst at beat 7 on port 2.
    reset_all();
    remaining[2] = 50;
    for (int c = 0; c < 11; c++) begin
      bus.fifo_full = (c == 3);
      rstn = !(c == 8);
      if (c == 9) begin remaining[0] = 2; remaining[3] = 2; end
      cycle();
      gv_log[c] = s_gv; wr_log[c] = s_wr; idx_log[c] = s_idx;
      rdy_log[c] = s_rdy; ovf_log[c] = s_ovf;
    end
    chk("t6_beat7_written", wr_log[8], 1'b1);
    chk("t6_ovf_before", ovf_log[8], 4'b0100);
    chk("t6_rdy_after", rdy_log[9], '0);
    chk("t6_gv_after", gv_log[9], 1'b0);
    chk("t6_ovf_after", ovf_log[9], '0);
    chk("t6_first_grant", idx_log[10], 0);
    chk("t6_first_gv", gv_log[10], 1'b1);

    // Randomized traffic, backpressure, enable toggling and occasional reset.
    reset_all();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (remaining[i] == 0 && $urandom_range(0, 3) == 0) remaining[i] = $urandom_range(1, 40);
        hold[i] = ($urandom_range(0, 9) == 0);
      end
      bus.fifo_full = ($urandom_range(0, 4) == 0);
      arb_enable    = ($urandom_range(0, 9) != 0);
      rstn          = ($urandom_range(0, 499) != 0);
      cycle();
    end
    rstn = 1'b1;
    for (int i = 0; i < N; i++) remaining[i] = 0;
    bus.fifo_full = 1'b0;
    for (int c = 0; c < 4; c++) cycle();
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
